// File: rtl/exec_unit_arbiter.sv
// rtl/exec_unit_arbiter.sv - round-robin arbiter sharing one exec_unit between two requesters
//
// Purpose:
//    Two requesters (req0 = integer issue slot, req1 = address-gen/branch-target slot)
//    compete for a single combinational exec_unit. The winner's operands drive eu_*;
//    the exec_unit result is captured into a one-entry response register.
//
// Ports:
//    clk, rst_n              clock, asynchronous active-low reset
//    reqN_valid_i/ready_o    request handshake (N = 0,1), fire = valid && ready
//    reqN_pc/rs1/rs2/imm_i   32-bit operands
//    reqN_params_i           6-bit operand selects + exec_op
//    reqN_tag_i              opaque tag returned with the response
//    eu_pc/rs1/rs2/imm_o     operands to the exec_unit (0 when nothing is granted)
//    eu_params_o             params to the exec_unit
//    eu_result_i             combinational exec_unit result
//    rsp_valid_o/ready_i     response handshake
//    rsp_result/src/tag_o    registered result, producing requester, its tag
//    perf_grant0/1_o,
//    perf_stall_o            saturating counters, present only with EXEC_ARB_PERF_EN
//
// Build option: define EXEC_ARB_PERF_EN to add the performance counters.

module exec_unit_arbiter #(
   parameter int TAG_W = 4
`ifdef EXEC_ARB_PERF_EN
   ,
   parameter int PERF_CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [31:0]      req0_pc_i,
   input  logic [31:0]      req0_rs1_i,
   input  logic [31:0]      req0_rs2_i,
   input  logic [31:0]      req0_imm_i,
   input  logic [5:0]       req0_params_i,
   input  logic [TAG_W-1:0] req0_tag_i,

   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [31:0]      req1_pc_i,
   input  logic [31:0]      req1_rs1_i,
   input  logic [31:0]      req1_rs2_i,
   input  logic [31:0]      req1_imm_i,
   input  logic [5:0]       req1_params_i,
   input  logic [TAG_W-1:0] req1_tag_i,

   output logic [31:0]      eu_pc_o,
   output logic [31:0]      eu_rs1_o,
   output logic [31:0]      eu_rs2_o,
   output logic [31:0]      eu_imm_o,
   output logic [5:0]       eu_params_o,
   input  logic [31:0]      eu_result_i,

   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_result_o,
   output logic             rsp_src_o,
   output logic [TAG_W-1:0] rsp_tag_o
`ifdef EXEC_ARB_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_grant0_o,
   output logic [PERF_CNT_W-1:0] perf_grant1_o,
   output logic [PERF_CNT_W-1:0] perf_stall_o
`endif
);

   logic             rsp_valid_q;
   logic [31:0]      rsp_result_q;
   logic             rsp_src_q;
   logic [TAG_W-1:0] rsp_tag_q;
   logic             last_grant_q;

   logic             can_issue;
   logic             grant_vld;
   logic             grant_idx;
   logic             fire;
   logic [TAG_W-1:0] grant_tag;

   // The response slot can take a new result when empty or being drained this cycle.
   assign can_issue = !rsp_valid_q || rsp_ready_i;

   // On conflict, the requester that did not win last time goes first.
   always_comb begin
      grant_vld = req0_valid_i || req1_valid_i;
      if (req0_valid_i && req1_valid_i) begin
         grant_idx = ~last_grant_q;
      end else begin
         grant_idx = req1_valid_i;
      end
   end

   assign fire         = can_issue && grant_vld;
   assign req0_ready_o = fire && !grant_idx;
   assign req1_ready_o = fire && grant_idx;

   always_comb begin
      eu_pc_o     = '0;
      eu_rs1_o    = '0;
      eu_rs2_o    = '0;
      eu_imm_o    = '0;
      eu_params_o = '0;
      grant_tag   = '0;
      if (grant_vld) begin
         if (grant_idx) begin
            eu_pc_o     = req1_pc_i;
            eu_rs1_o    = req1_rs1_i;
            eu_rs2_o    = req1_rs2_i;
            eu_imm_o    = req1_imm_i;
            eu_params_o = req1_params_i;
            grant_tag   = req1_tag_i;
         end else begin
            eu_pc_o     = req0_pc_i;
            eu_rs1_o    = req0_rs1_i;
            eu_rs2_o    = req0_rs2_i;
            eu_imm_o    = req0_imm_i;
            eu_params_o = req0_params_i;
            grant_tag   = req0_tag_i;
         end
      end
   end

   // last_grant resets to 1 so req0 wins the first conflict after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_src_q    <= 1'b0;
         rsp_tag_q    <= '0;
         last_grant_q <= 1'b1;
      end else if (fire) begin
         // A same-cycle drain is implied: the new result overwrites the old one.
         rsp_valid_q  <= 1'b1;
         rsp_result_q <= eu_result_i;
         rsp_src_q    <= grant_idx;
         rsp_tag_q    <= grant_tag;
         last_grant_q <= grant_idx;
      end else if (rsp_ready_i) begin
         rsp_valid_q  <= 1'b0;
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_src_o    = rsp_src_q;
   assign rsp_tag_o    = rsp_tag_q;

`ifdef EXEC_ARB_PERF_EN
   logic [PERF_CNT_W-1:0] perf_grant0_q;
   logic [PERF_CNT_W-1:0] perf_grant1_q;
   logic [PERF_CNT_W-1:0] perf_stall_q;
   logic                  stall;

   assign stall = (req0_valid_i || req1_valid_i) && !can_issue;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grant0_q <= '0;
         perf_grant1_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (req0_ready_o && (perf_grant0_q != '1)) begin
            perf_grant0_q <= perf_grant0_q + PERF_CNT_W'(1);
         end
         if (req1_ready_o && (perf_grant1_q != '1)) begin
            perf_grant1_q <= perf_grant1_q + PERF_CNT_W'(1);
         end
         if (stall && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + PERF_CNT_W'(1);
         end
      end
   end

   assign perf_grant0_o = perf_grant0_q;
   assign perf_grant1_o = perf_grant1_q;
   assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_exec_unit_arbiter.sv
// tb/tb_exec_unit_arbiter.sv - directed self-checking bench for exec_unit_arbiter

module tb_exec_unit_arbiter;

   localparam int TAG_W = 4;

   logic             clk;
   logic             rst_n;
   logic             req0_valid, req0_ready;
   logic [31:0]      req0_pc, req0_rs1, req0_rs2, req0_imm;
   logic [5:0]       req0_params;
   logic [TAG_W-1:0] req0_tag;
   logic             req1_valid, req1_ready;
   logic [31:0]      req1_pc, req1_rs1, req1_rs2, req1_imm;
   logic [5:0]       req1_params;
   logic [TAG_W-1:0] req1_tag;
   logic [31:0]      eu_pc, eu_rs1, eu_rs2, eu_imm;
   logic [5:0]       eu_params;
   logic [31:0]      eu_result;
   logic             rsp_valid, rsp_ready;
   logic [31:0]      rsp_result;
   logic             rsp_src;
   logic [TAG_W-1:0] rsp_tag;
`ifdef EXEC_ARB_PERF_EN
   logic [3:0]       perf_grant0, perf_grant1, perf_stall;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   exec_unit_arbiter #(
      .TAG_W(TAG_W)
`ifdef EXEC_ARB_PERF_EN
      ,
      .PERF_CNT_W(4)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
      .req0_pc_i(req0_pc), .req0_rs1_i(req0_rs1), .req0_rs2_i(req0_rs2),
      .req0_imm_i(req0_imm), .req0_params_i(req0_params), .req0_tag_i(req0_tag),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
      .req1_pc_i(req1_pc), .req1_rs1_i(req1_rs1), .req1_rs2_i(req1_rs2),
      .req1_imm_i(req1_imm), .req1_params_i(req1_params), .req1_tag_i(req1_tag),
      .eu_pc_o(eu_pc), .eu_rs1_o(eu_rs1), .eu_rs2_o(eu_rs2), .eu_imm_o(eu_imm),
      .eu_params_o(eu_params), .eu_result_i(eu_result),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_result_o(rsp_result), .rsp_src_o(rsp_src), .rsp_tag_o(rsp_tag)
`ifdef EXEC_ARB_PERF_EN
      ,
      .perf_grant0_o(perf_grant0), .perf_grant1_o(perf_grant1), .perf_stall_o(perf_stall)
`endif
   );

   // Stand-in exec_unit: params[5] op1 sel (0 rs1, 1 pc), params[4] op2 sel (0 rs2, 1 imm),
   // params[3:0] op (0 ADD, 1 SUB, 2 SRA).
   logic [31:0] op1, op2;
   always_comb begin
      op1       = eu_params[5] ? eu_pc  : eu_rs1;
      op2       = eu_params[4] ? eu_imm : eu_rs2;
      eu_result = op1 + op2;
      case (eu_params[3:0])
         4'd1:    eu_result = op1 - op2;
         4'd2:    eu_result = $unsigned($signed(op1) >>> op2[4:0]);
         default: eu_result = op1 + op2;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req0(input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [5:0] p, input logic [3:0] t);
      req0_valid = v; req0_pc = 32'h0; req0_rs1 = rs1; req0_rs2 = rs2;
      req0_imm = imm; req0_params = p; req0_tag = t;
   endtask

   task automatic set_req1(input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [5:0] p, input logic [3:0] t);
      req1_valid = v; req1_pc = 32'h0; req1_rs1 = rs1; req1_rs2 = rs2;
      req1_imm = imm; req1_params = p; req1_tag = t;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      set_req0(1'b0, 0, 0, 0, 6'h0, 4'h0);
      set_req1(1'b0, 0, 0, 0, 6'h0, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // Reset state with nothing requested.
      #1;
      chk("rst_rsp_valid",  32'(rsp_valid), 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_src",    32'(rsp_src), 0);
      chk("rst_rsp_tag",    32'(rsp_tag), 0);
      chk("idle_ready0",    32'(req0_ready), 0);
      chk("idle_ready1",    32'(req1_ready), 0);
      chk("idle_eu_rs1",    eu_rs1, 0);
      chk("idle_eu_params", 32'(eu_params), 0);

      // req0 ADD rs1=5 + imm=7, tag 3.
      @(negedge clk);
      set_req0(1'b1, 32'd5, 32'd0, 32'd7, 6'h10, 4'd3);
      #1;
      chk("t1_ready0", 32'(req0_ready), 1);
      chk("t1_ready1", 32'(req1_ready), 0);
      chk("t1_eu_rs1", eu_rs1, 5);
      @(posedge clk); #1;
      chk("t1_rsp_valid",  32'(rsp_valid), 1);
      chk("t1_rsp_result", rsp_result, 12);
      chk("t1_rsp_src",    32'(rsp_src), 0);
      chk("t1_rsp_tag",    32'(rsp_tag), 3);

      // req0 SRA 0x80000000 >>> 4.
      @(negedge clk);
      set_req0(1'b1, 32'h8000_0000, 32'd0, 32'd4, 6'h12, 4'd6);
      #1;
      chk("sra_ready0", 32'(req0_ready), 1);
      @(posedge clk); #1;
      chk("sra_result", rsp_result, 32'hF800_0000);
      chk("sra_src",    32'(rsp_src), 0);

      // req1 SUB 3 - 5.
      @(negedge clk);
      set_req0(1'b0, 0, 0, 0, 6'h0, 4'h0);
      set_req1(1'b1, 32'd3, 32'd5, 32'd0, 6'h01, 4'd9);
      #1;
      chk("sub_ready1", 32'(req1_ready), 1);
      @(posedge clk); #1;
      chk("sub_result", rsp_result, 32'hFFFF_FFFE);
      chk("sub_src",    32'(rsp_src), 1);
      chk("sub_tag",    32'(rsp_tag), 9);

      // Both valid for 8 ops: req0 ADD 100+20, req1 SUB 50-8; last winner was req1.
      @(negedge clk);
      set_req0(1'b1, 32'd100, 32'd20, 32'd0, 6'h00, 4'hA);
      set_req1(1'b1, 32'd50,  32'd8,  32'd0, 6'h01, 4'h5);
      for (int k = 0; k < 8; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         chk($sformatf("rr%0d_ready0", k), 32'(req0_ready), (k % 2 == 0) ? 1 : 0);
         chk($sformatf("rr%0d_ready1", k), 32'(req1_ready), (k % 2 == 1) ? 1 : 0);
         @(posedge clk); #1;
         chk($sformatf("rr%0d_valid", k),  32'(rsp_valid), 1);
         chk($sformatf("rr%0d_src", k),    32'(rsp_src), k % 2);
         chk($sformatf("rr%0d_result", k), rsp_result, (k % 2 == 0) ? 120 : 42);
         chk($sformatf("rr%0d_tag", k),    32'(rsp_tag), (k % 2 == 0) ? 10 : 5);
      end

      // Backpressure: req1's result (42, tag 5) is held for 3 cycles.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rsp_ready = 1'b0;
         #1;
         chk($sformatf("bp%0d_ready0", k), 32'(req0_ready), 0);
         chk($sformatf("bp%0d_ready1", k), 32'(req1_ready), 0);
         @(posedge clk); #1;
         chk($sformatf("bp%0d_valid", k),  32'(rsp_valid), 1);
         chk($sformatf("bp%0d_result", k), rsp_result, 42);
         chk($sformatf("bp%0d_src", k),    32'(rsp_src), 1);
         chk($sformatf("bp%0d_tag", k),    32'(rsp_tag), 5);
      end
      // Release: drain and fire together, req0 wins.
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("bprel_ready0", 32'(req0_ready), 1);
      @(posedge clk); #1;
      chk("bprel_valid",  32'(rsp_valid), 1);
      chk("bprel_result", rsp_result, 120);
      chk("bprel_src",    32'(rsp_src), 0);

      // Drain with no new request: valid drops, data holds.
      @(negedge clk);
      set_req0(1'b0, 0, 0, 0, 6'h0, 4'h0);
      set_req1(1'b0, 0, 0, 0, 6'h0, 4'h0);
      @(posedge clk); #1;
      chk("drain_valid",  32'(rsp_valid), 0);
      chk("drain_result", rsp_result, 120);
      chk("drain_tag",    32'(rsp_tag), 10);

      // Async reset mid-cycle while a response is pending.
      @(negedge clk);
      set_req1(1'b1, 32'd50, 32'd8, 32'd0, 6'h01, 4'h5);
      @(posedge clk); #1;
      chk("pre_arst_valid", 32'(rsp_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid",  32'(rsp_valid), 0);
      chk("arst_result", rsp_result, 0);
      chk("arst_src",    32'(rsp_src), 0);
      @(negedge clk);
      set_req0(1'b1, 32'd100, 32'd20, 32'd0, 6'h00, 4'hA);
      rst_n = 1'b1;
      #1;
      chk("post_arst_ready0", 32'(req0_ready), 1);
      chk("post_arst_ready1", 32'(req1_ready), 0);
      @(posedge clk); #1;
      chk("post_arst_src",    32'(rsp_src), 0);
      chk("post_arst_result", rsp_result, 120);

`ifdef EXEC_ARB_PERF_EN
      // 1 fire, 2 stalled cycles, 19 more fires: grant0 saturates at 15, stall = 2.
      do_reset();
      set_req0(1'b1, 32'd1, 32'd1, 32'd0, 6'h00, 4'h1);
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b1;
      repeat (19) @(posedge clk);
      @(negedge clk);
      set_req0(1'b0, 0, 0, 0, 6'h0, 4'h0);
      #1;
      chk("perf_grant0", 32'(perf_grant0), 15);
      chk("perf_grant1", 32'(perf_grant1), 0);
      chk("perf_stall",  32'(perf_stall), 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_unit_arbiter.md
Name: exec_unit_arbiter

Overview:
- Shares one combinational exec_unit between two requesters, e.g. the integer issue slot (req0) and the address-generation/branch-target slot (req1).
- Arbitrates round-robin, drives the exec_unit operand and params inputs from the winner, and captures the result into a one-entry output register with a valid/ready response interface.
- Sits between issue/dispatch and writeback.

Parameters:
TAG_W, 4, width of the requester-supplied tag carried through to the response
PERF_CNT_W, 16, width of each performance counter (used only with EXEC_ARB_PERF_EN)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
reqN_valid  input  1  request N (N=0,1) holds a valid operation
reqN_ready  output  1  request N accepted this cycle (fire = valid && ready)
reqN_pc  input  32 (arch_reg)  PC operand for request N
reqN_rs1  input  32  rs1 operand
reqN_rs2  input  32  rs2 operand
reqN_imm  input  32  immediate operand
reqN_params  input  6 (exec_unit_params)  operand selects and exec_op
reqN_tag  input  TAG_W  opaque tag, returned with the result
eu_pc, eu_rs1, eu_rs2, eu_imm  output  32 each  to exec_unit inputs
eu_params  output  6  to exec_unit params
eu_result  input  32  exec_unit exec_out (combinational)
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  consumer accepts the response
rsp_result  output  32  registered result
rsp_src  output  1  requester index that produced rsp_result
rsp_tag  output  TAG_W  tag of that request

Behaviour:
- Reset is asynchronous, active-low (rst_n). On reset:
  - rsp_valid=0, rsp_result=0, rsp_src=0, rsp_tag=0.
  - last_grant=1, so req0 wins the first conflict.
  - Perf counters=0.
  - A pending response is discarded.
- can_issue = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Only one valid: that requester.
  - Both valid: the requester != last_grant.
  - Neither valid: none.
- reqN_ready = can_issue && grant==N. At most one ready per cycle; both low when no grant or when !can_issue.
- eu_* are muxed combinationally from the granted requester.
  - With no grant, eu_* = 0. Params 0 = OP1_SEL_REG / OP2_SEL_REG / EXEC_OP_ADD.
- On fire of requester N, at the next edge:
  - rsp_result <= eu_result, rsp_src <= N, rsp_tag <= reqN_tag, rsp_valid <= 1.
  - last_grant <= N.
- last_grant updates only on fire, never on an idle cycle or a blocked cycle.
- rsp_valid && rsp_ready with no fire: rsp_valid <= 0. rsp_result/src/tag hold their last values.
- Drain and fire in the same cycle: the new result replaces the old one. Throughput is 1 op/cycle, latency 1 cycle from fire to rsp_valid.
- rsp_valid && !rsp_ready: all rsp_* hold stable and both reqN_ready=0.
- Requester rule (bench assertion): once valid, reqN_* stay stable and valid stays high until fire.
- Fairness: both requesters continuously valid with rsp_ready=1 gives grants 0,1,0,1,... Neither requester waits more than one grant.
- Arithmetic is performed entirely by exec_unit. The arbiter never modifies operands or the result.

Optional Feature:
Macro: EXEC_ARB_PERF_EN
- With the macro defined, three output ports are added, each PERF_CNT_W wide and saturating at all-ones:
  - perf_grant0: counts req0 fires.
  - perf_grant1: counts req1 fires.
  - perf_stall: counts cycles with (req0_valid || req1_valid) && !can_issue.
  - All three are reset to 0 by rst_n.
- Without the macro: no counter ports and no counter logic. Functional behaviour is identical.

Test Plan:
1. Reset, then req0 only with rs1=5, imm=7, params {OP1_SEL_REG, OP2_SEL_IMM, EXEC_OP_ADD}, tag=3, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_result=12, rsp_src=0, rsp_tag=3.
2. Both requesters valid continuously for 8 ops (req0 ADD, req1 SUB), rsp_ready=1 -> rsp_src sequence 0,1,0,1,0,1,0,1, one response per cycle, no gaps.
3. req1 SUB rs1=3, rs2=5 -> rsp_result=0xFFFFFFFE. req0 SRA rs1=0x80000000, imm=4 -> rsp_result=0xF8000000.
4. Backpressure: response pending with rsp_ready=0 for 3 cycles while both requesters are valid -> reqN_ready=0 and rsp_* unchanged for all 3 cycles; raise rsp_ready -> old response drained and a new op fired in the same cycle.
5. Assert rst_n=0 mid-cycle while rsp_valid=1 -> rsp_valid=0 immediately, without waiting for a clock edge. After release with both requesters valid, req0 is granted first.
6. With EXEC_ARB_PERF_EN and PERF_CNT_W=4: 20 req0 fires -> perf_grant0 saturates at 15. 2 blocked cycles -> perf_stall=2.
